// File: rtl/bus_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bus_pkg : shared constants and FSM encoding for the data-bus fabric
// Revision: 1.0
// ---------------------------------------------------------------------------
package bus_pkg;
    localparam int          LAT_W            = 4;
    localparam int          ERR_CNT_W        = 16;
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef logic [0:0] state_t;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;
endpackage
`default_nettype wire

// File: rtl/bus_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bus_decoder : address -> one-hot region hit, index, base-relative offset
// Revision: 1.0
// ---------------------------------------------------------------------------
module bus_decoder
    import bus_pkg::*;
#(
    parameter int                        REGIONS     = 5,
    parameter int                        ADDR_W      = 32,
    parameter int                        SEL_W       = (REGIONS > 1) ? $clog2(REGIONS) : 1,
    parameter logic [REGIONS*ADDR_W-1:0] REGION_BASE = '0,
    parameter logic [REGIONS*ADDR_W-1:0] REGION_END  = '0
) (
    input  logic [ADDR_W-1:0]  addr_i,
    output logic [REGIONS-1:0] hit_o,
    output logic [SEL_W-1:0]   sel_o,
    output logic [ADDR_W-1:0]  offset_o,
    output logic               mapped_o
);
    // Scan from the top index down so the lowest matching region wins.
    always_comb begin
        hit_o    = '0;
        sel_o    = '0;
        offset_o = '0;
        mapped_o = 1'b0;
        for (int i = REGIONS - 1; i >= 0; i--) begin
            if ((addr_i >= REGION_BASE[i*ADDR_W +: ADDR_W]) &&
                (addr_i <  REGION_END[i*ADDR_W +: ADDR_W])) begin
                hit_o    = '0;
                hit_o[i] = 1'b1;
                sel_o    = SEL_W'(i);
                offset_o = addr_i - REGION_BASE[i*ADDR_W +: ADDR_W];
                mapped_o = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/bus_fabric.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bus_fabric : single-master, N-slave bus with per-region read latency
// Revision: 1.0
// ---------------------------------------------------------------------------
module bus_fabric
    import bus_pkg::*;
#(
    parameter int                        REGIONS     = 5,
    parameter int                        ADDR_W      = 32,
    parameter int                        DATA_W      = 32,
    parameter logic [REGIONS*ADDR_W-1:0] REGION_BASE = '0,
    parameter logic [REGIONS*ADDR_W-1:0] REGION_END  = '0,
    parameter logic [REGIONS*LAT_W-1:0]  REGION_LAT  = {REGIONS{4'd1}},
    parameter logic [DATA_W-1:0]         ERR_DATA    = DATA_W'(ERR_DATA_DEFAULT)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        m_req_i,
    input  logic                        m_we_i,
    input  logic [ADDR_W-1:0]           m_addr_i,
    input  logic [DATA_W-1:0]           m_wd_i,
    output logic                        m_ready_o,
    output logic                        m_rvalid_o,
    output logic [DATA_W-1:0]           m_rdata_o,
    output logic                        m_err_o,
    output logic [REGIONS-1:0]          s_en_o,
    output logic [REGIONS-1:0]          s_we_o,
    output logic [REGIONS*ADDR_W-1:0]   s_addr_o,
    output logic [REGIONS*DATA_W-1:0]   s_wd_o,
    input  logic [REGIONS*DATA_W-1:0]   s_rd_i,
    output logic [ADDR_W-1:0]           err_addr_o,
    output logic [ERR_CNT_W-1:0]        err_count_o
);
    localparam int SEL_W = (REGIONS > 1) ? $clog2(REGIONS) : 1;

    logic [REGIONS-1:0] dec_hit;
    logic [SEL_W-1:0]   dec_sel;
    logic [ADDR_W-1:0]  dec_off;
    logic               dec_mapped;
    logic               accept;
    logic [LAT_W-1:0]   lat;

    state_t               state_q,    state_d;
    logic [LAT_W-1:0]     cnt_q,      cnt_d;
    logic [SEL_W-1:0]     sel_q,      sel_d;
    logic [ADDR_W-1:0]    off_q,      off_d;
    logic                 rvalid_q,   rvalid_d;
    logic [DATA_W-1:0]    rdata_q,    rdata_d;
    logic                 err_q,      err_d;
    logic [ADDR_W-1:0]    err_addr_q, err_addr_d;
    logic [ERR_CNT_W-1:0] err_cnt_q,  err_cnt_d;

    bus_decoder #(
        .REGIONS     (REGIONS),
        .ADDR_W      (ADDR_W),
        .SEL_W       (SEL_W),
        .REGION_BASE (REGION_BASE),
        .REGION_END  (REGION_END)
    ) u_dec (
        .addr_i   (m_addr_i),
        .hit_o    (dec_hit),
        .sel_o    (dec_sel),
        .offset_o (dec_off),
        .mapped_o (dec_mapped)
    );

    assign m_ready_o   = (state_q == ST_IDLE);
    assign accept      = m_req_i && m_ready_o;
    assign lat         = REGION_LAT[dec_sel*LAT_W +: LAT_W];
    assign s_wd_o      = {REGIONS{m_wd_i}};
    assign m_rvalid_o  = rvalid_q;
    assign m_rdata_o   = rdata_q;
    assign m_err_o     = err_q;
    assign err_addr_o  = err_addr_q;
    assign err_count_o = err_cnt_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        off_d      = off_q;
        rvalid_d   = 1'b0;
        rdata_d    = rdata_q;
        err_d      = 1'b0;
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;
        s_en_o     = '0;
        s_we_o     = '0;
        s_addr_o   = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept && dec_mapped) begin
                    s_en_o = dec_hit;
                    s_addr_o[dec_sel*ADDR_W +: ADDR_W] = dec_off;
                    if (m_we_i) begin
                        s_we_o = dec_hit;
                    end else if (lat == '0) begin
                        rvalid_d = 1'b1;
                        rdata_d  = s_rd_i[dec_sel*DATA_W +: DATA_W];
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = lat - 1'b1;
                        sel_d   = dec_sel;
                        off_d   = dec_off;
                    end
                end else if (accept) begin
                    err_d      = 1'b1;
                    err_addr_d = m_addr_i;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    if (!m_we_i) begin
                        rvalid_d = 1'b1;
                        rdata_d  = ERR_DATA;
                    end
                end
            end
            ST_WAIT: begin
                // Slave sees a stable enable/offset for the whole access.
                s_en_o[sel_q] = 1'b1;
                s_addr_o[sel_q*ADDR_W +: ADDR_W] = off_q;
                if (cnt_q == '0) begin
                    rvalid_d = 1'b1;
                    rdata_d  = s_rd_i[sel_q*DATA_W +: DATA_W];
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sel_q      <= '0;
            off_q      <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            off_q      <= off_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_bus_fabric.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bus_fabric : transaction-schedule model of the fabric, directed + random
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_bus_fabric;
    localparam int NR = 5;
    localparam logic [NR*32-1:0] P_BASE = {32'h50000, 32'h10000, 32'h2000, 32'h1000, 32'h0};
    localparam logic [NR*32-1:0] P_END  = {32'h60000, 32'h20000, 32'h3000, 32'h2000, 32'h1000};
    // Region 3 uses latency 4 so one build covers L=0, L=1 and a long wait.
    localparam logic [NR*4-1:0]  P_LAT  = {4'd1, 4'd4, 4'd0, 4'd1, 4'd1};

    logic clk_i = 1'b0, reset_i = 1'b1;
    logic m_req_i = 1'b0, m_we_i = 1'b0;
    logic [31:0] m_addr_i = '0, m_wd_i = '0;
    logic m_ready_o, m_rvalid_o, m_err_o;
    logic [31:0] m_rdata_o, err_addr_o;
    logic [15:0] err_count_o;
    logic [NR-1:0] s_en_o, s_we_o;
    logic [NR*32-1:0] s_addr_o, s_wd_o, s_rd_i;
    logic [31:0] noise [NR];

    int checks = 0, failures = 0;

    bus_fabric #(
        .REGIONS(NR), .ADDR_W(32), .DATA_W(32),
        .REGION_BASE(P_BASE), .REGION_END(P_END), .REGION_LAT(P_LAT),
        .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .m_req_i(m_req_i), .m_we_i(m_we_i),
        .m_addr_i(m_addr_i), .m_wd_i(m_wd_i), .m_ready_o(m_ready_o),
        .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
        .s_en_o(s_en_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wd_o(s_wd_o),
        .s_rd_i(s_rd_i), .err_addr_o(err_addr_o), .err_count_o(err_count_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] hsh(input int r, input logic [31:0] off);
        return {4'hC, 4'(r), off[23:0]};
    endfunction

    // Enabled slaves answer with a pattern of their offset; idle slaves return noise.
    always_comb begin
        s_rd_i = '0;
        for (int i = 0; i < NR; i++)
            s_rd_i[i*32 +: 32] = s_en_o[i] ? hsh(i, s_addr_o[i*32 +: 32]) : noise[i];
    end

    // Model: memory map, plus a cycle-indexed schedule of responses.
    logic [31:0] mb [NR] = '{32'h0, 32'h1000, 32'h2000, 32'h10000, 32'h50000};
    logic [31:0] me [NR] = '{32'h1000, 32'h2000, 32'h3000, 32'h20000, 32'h60000};
    int          ml [NR] = '{1, 1, 0, 4, 1};

    int          cyc = 0, busy_until = 0, hold_until = 0, hold_idx = 0;
    logic [31:0] hold_off, cur_rdata, merr_addr;
    logic [15:0] merr_cnt;
    logic        sch_rv [64], sch_err [64], sch_eu [64];
    logic [31:0] sch_data [64], sch_ea [64];

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            sch_rv[i] = 0; sch_err[i] = 0; sch_eu[i] = 0; sch_data[i] = '0; sch_ea[i] = '0;
        end
        busy_until = cyc; hold_until = 0; hold_off = '0;
        cur_rdata = '0; merr_addr = '0; merr_cnt = '0;
    endtask

    task automatic step(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, output logic acc);
        int slot, r, due;
        logic [31:0] off;
        logic e_rv, e_err, e_rdy;
        logic [NR-1:0] e_en, e_we;
        logic [NR*32-1:0] e_sa;
        @(posedge clk_i); #1;
        slot = cyc % 64;
        if (sch_rv[slot]) cur_rdata = sch_data[slot];
        e_rv = sch_rv[slot]; e_err = sch_err[slot];
        if (sch_eu[slot]) begin
            merr_addr = sch_ea[slot];
            if (merr_cnt != 16'hFFFF) merr_cnt = merr_cnt + 16'd1;
        end
        sch_rv[slot] = 0; sch_err[slot] = 0; sch_eu[slot] = 0;
        e_rdy = (cyc >= busy_until);
        acc = req && e_rdy;
        e_en = '0; e_we = '0; e_sa = '0;
        if (cyc < hold_until) begin
            e_en[hold_idx] = 1'b1;
            e_sa[hold_idx*32 +: 32] = hold_off;
        end
        if (acc) begin
            r = -1;
            for (int i = NR - 1; i >= 0; i--)
                if (addr >= mb[i] && addr < me[i]) r = i;
            if (r >= 0) begin
                off = addr - mb[r];
                e_en[r] = 1'b1;
                e_sa[r*32 +: 32] = off;
                if (we) e_we[r] = 1'b1;
                else begin
                    due = (cyc + ml[r] + 1) % 64;
                    sch_rv[due] = 1; sch_data[due] = hsh(r, off);
                    if (ml[r] > 0) begin
                        busy_until = cyc + ml[r] + 1;
                        hold_until = cyc + ml[r] + 1;
                        hold_idx = r; hold_off = off;
                    end
                end
            end else begin
                due = (cyc + 1) % 64;
                sch_err[due] = 1; sch_eu[due] = 1; sch_ea[due] = addr;
                if (!we) begin sch_rv[due] = 1; sch_data[due] = 32'hDEAD_BEEF; end
            end
        end
        m_req_i = req; m_we_i = we; m_addr_i = addr; m_wd_i = wd;
        for (int i = 0; i < NR; i++) noise[i] = $urandom();
        @(negedge clk_i);
        chk("m_ready",   {191'd0, m_ready_o},  {191'd0, e_rdy});
        chk("m_rvalid",  {191'd0, m_rvalid_o}, {191'd0, e_rv});
        chk("m_err",     {191'd0, m_err_o},    {191'd0, e_err});
        chk("m_rdata",   m_rdata_o,   cur_rdata);
        chk("s_en",      s_en_o,      e_en);
        chk("s_we",      s_we_o,      e_we);
        chk("s_addr",    s_addr_o,    e_sa);
        chk("s_wd",      s_wd_o,      {NR{wd}});
        chk("err_addr",  err_addr_o,  merr_addr);
        chk("err_count", err_count_o, merr_cnt);
        cyc++;
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         output int acc_cyc);
        logic acc;
        acc = 0;
        acc_cyc = -1;
        for (int n = 0; n < 40 && !acc; n++) begin
            step(1'b1, we, addr, wd, acc);
            if (acc) acc_cyc = cyc - 1;
        end
        if (!acc) begin
            failures++;
            $display("FAIL accept_timeout addr=%0h actual=not_accepted required=accepted", addr);
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int k = 0; k < n; k++) step(1'b0, 1'($urandom_range(0, 1)), $urandom(), $urandom(), acc);
    endtask

    function automatic logic [31:0] rand_addr();
        int k;
        k = int'($urandom_range(0, 6));
        if (k < NR) begin
            case ($urandom_range(0, 3))
                0:       return mb[k];
                1:       return me[k] - 32'd1;
                default: return mb[k] + ($urandom() % (me[k] - mb[k]));
            endcase
        end else if (k == 5) return 32'h3000 + ($urandom() % 32'hD000);
        else return 32'h8000_0000 | $urandom();
    endfunction

    initial begin
        int a1, a2;
        logic acc, pend, pw;
        logic [31:0] pa, pd;
        model_reset();
        for (int i = 0; i < NR; i++) noise[i] = '0;
        repeat (2) @(posedge clk_i);
        #2;
        chk("rst_ready",  {191'd0, m_ready_o},  192'd1);
        chk("rst_rvalid", {191'd0, m_rvalid_o}, 192'd0);
        chk("rst_rdata",  m_rdata_o,  32'h0);
        chk("rst_errcnt", err_count_o, 16'h0);
        chk("rst_s_en",   s_en_o,      5'b0);
        reset_i = 1'b0;

        // L=1 read of region 1
        issue(1'b0, 32'h1004, 32'h0, a1);
        chk("r1_en",    s_en_o, 5'b00010);
        chk("r1_saddr", s_addr_o[63:32], 32'h4);
        idle(1);
        chk("r1_busy",  {191'd0, m_ready_o}, 192'd0);
        idle(1);
        chk("r1_rvalid", {191'd0, m_rvalid_o}, 192'd1);
        chk("r1_rdata",  m_rdata_o, 32'hC100_0004);

        // back-to-back L=0 reads of region 2
        issue(1'b0, 32'h2010, 32'h0, a1);
        issue(1'b0, 32'h2014, 32'h0, a2);
        chk("pio_b2b",    a2 - a1, 192'd1);
        chk("pio_rdata0", m_rdata_o, 32'hC200_0010);
        idle(1);
        chk("pio_rdata1", m_rdata_o, 32'hC200_0014);

        // back-to-back writes
        issue(1'b1, 32'h1000, 32'hA5, a1);
        chk("wr0_we", s_we_o, 5'b00010);
        issue(1'b1, 32'h1004, 32'h5A, a2);
        chk("wr1_we", s_we_o, 5'b00010);
        chk("wr1_wd", s_wd_o[63:32], 32'h5A);
        chk("wr_b2b", a2 - a1, 192'd1);
        idle(1);
        chk("wr_no_rvalid", {191'd0, m_rvalid_o}, 192'd0);

        // unmapped read
        issue(1'b0, 32'h9_0000, 32'h0, a1);
        idle(1);
        chk("um_err",    {191'd0, m_err_o}, 192'd1);
        chk("um_rdata",  m_rdata_o, 32'hDEAD_BEEF);
        chk("um_eaddr",  err_addr_o, 32'h9_0000);
        chk("um_ecount", err_count_o, 16'd1);

        // L=4 read of region 3
        issue(1'b0, 32'h1_0008, 32'h0, a1);
        for (int k = 0; k < 4; k++) begin
            idle(1);
            chk("l4_busy",  {191'd0, m_ready_o}, 192'd0);
            chk("l4_saddr", s_addr_o[127:96], 32'h8);
        end
        idle(1);
        chk("l4_rvalid", {191'd0, m_rvalid_o}, 192'd1);
        chk("l4_rdata",  m_rdata_o, 32'hC300_0008);

        // reset in the middle of a wait
        issue(1'b0, 32'h1_0008, 32'h0, a1);
        m_req_i = 1'b0;
        @(posedge clk_i); #2;
        reset_i = 1'b1;
        #1;
        chk("wrst_ready", {191'd0, m_ready_o}, 192'd1);
        chk("wrst_s_en",  s_en_o, 5'b0);
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        model_reset();
        idle(6);
        issue(1'b0, 32'h1004, 32'h0, a1);
        idle(2);
        chk("wrst_rdata", m_rdata_o, 32'hC100_0004);

        // randomized traffic; an unaccepted request is held unchanged
        pend = 0; pw = 0; pa = '0; pd = '0;
        repeat (3000) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend = 1; pw = 1'($urandom_range(0, 1)); pa = rand_addr(); pd = $urandom();
            end
            if (pend) step(1'b1, pw, pa, pd, acc);
            else step(1'b0, 1'($urandom_range(0, 1)), $urandom(), $urandom(), acc);
            if (acc) pend = 0;
        end
        idle(6);

        // counter saturation
        for (int k = 0; k < 65536; k++) step(1'b1, 1'b1, 32'h9_0000 + 32'(k), 32'h0, acc);
        idle(2);
        chk("sat_ecount", err_count_o, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
